// File: rtl/gd_pkg.sv
// ---------------------------------------------------------------------------
// gd_pkg
// Shared definitions for the gradient-descent engine scheduler:
//   Q_W            - width of a Q24.8 fixed-point word (32)
//   Q_FRAC         - number of fraction bits in a Q24.8 word (8)
//   q24_8_t        - signed Q24.8 word type
//   sched_state_t  - scheduler FSM state encoding (IDLE, RUN, DRAIN, RESP)
// ---------------------------------------------------------------------------
package gd_pkg;

    localparam int Q_W    = 32;
    localparam int Q_FRAC = 8;

    typedef logic signed [Q_W-1:0] q24_8_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// gd_rr_arbiter
// Purely combinational round-robin selector. The search starts at
// last_i+1 (mod NUM_REQ) and returns the first asserted request.
// Ports:
//   req_i         in  NUM_REQ  request vector
//   last_i        in  IDW      index granted most recently
//   gnt_valid_o   out 1        at least one request is asserted
//   gnt_idx_o     out IDW      index of the selected request
//   gnt_onehot_o  out NUM_REQ  one-hot form of gnt_idx_o (zero if none)
// ---------------------------------------------------------------------------
module gd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic               gnt_valid_o,
    output logic [IDW-1:0]     gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_onehot_o
);

    always_comb begin
        int idx;
        gnt_valid_o  = 1'b0;
        gnt_idx_o    = '0;
        gnt_onehot_o = '0;
        idx          = 0;
        // Offsets 1..NUM_REQ visit every requester once, the last-granted
        // one at the very end, which gives it the lowest priority.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_i) + off) % NUM_REQ;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o       = 1'b1;
                gnt_idx_o         = idx[IDW-1:0];
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gd_engine_scheduler.sv
// ---------------------------------------------------------------------------
// gd_engine_scheduler
// Shares one gradient-descent engine between NUM_REQ requesters. A job is
// granted round-robin in IDLE, run on the engine (RUN), the engine's done
// level is allowed to fall (DRAIN), and the result is held until consumed
// (RESP).
//
// Optional feature macro: GD_TIMEOUT_EN
//   Defined   - a watchdog aborts a RUN lasting TIMEOUT_CYCLES cycles with
//               zeroed results and rsp_err=1.
//   Undefined - RUN waits for eng_done indefinitely, rsp_err is constant 0.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. req_ready is a combinational response to
// req_valid while IDLE; rsp_valid is held with stable data until rsp_ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_x/req_ready     requester side (req_x slice i = [32i+31:32i])
//   rsp_valid/rsp_ready           result handshake
//   rsp_id/rsp_x_at_min/rsp_y_min/rsp_err  result payload
//   eng_start/eng_x_in            engine command (level)
//   eng_done/eng_x_at_min/eng_y_min       engine status and results
//   busy                          high in every state but IDLE
//   dbg_state                     current FSM state (sched_state_t encoding)
// ---------------------------------------------------------------------------
module gd_engine_scheduler
    import gd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [Q_W*NUM_REQ-1:0]     req_x,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [Q_W-1:0]             rsp_x_at_min,
    output logic [Q_W-1:0]             rsp_y_min,
    output logic                       rsp_err,
    output logic                       eng_start,
    output logic [Q_W-1:0]             eng_x_in,
    input  logic                       eng_done,
    input  logic [Q_W-1:0]             eng_x_at_min,
    input  logic [Q_W-1:0]             eng_y_min,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);

    // Elaboration-time guard on the parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("gd_engine_scheduler: illegal NUM_REQ or TIMEOUT_CYCLES");
    end

    sched_state_t       state_q;
    logic [IDW-1:0]     last_grant_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [Q_W-1:0]     eng_x_q;
    logic [Q_W-1:0]     rsp_x_q;
    logic [Q_W-1:0]     rsp_y_q;
    logic               eng_start_q;
    logic               rsp_valid_q;
    logic               busy_q;

    logic               gnt_valid;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;

`ifdef GD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
`endif

    gd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i        (req_valid),
        .last_i       (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx),
        .gnt_onehot_o (gnt_onehot)
    );

    // Only IDLE accepts; reset masks acceptance even though the state
    // register may already read IDLE while rst is still high.
    assign req_ready = (state_q == ST_IDLE && !rst) ? gnt_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            eng_x_q      <= '0;
            rsp_x_q      <= '0;
            rsp_y_q      <= '0;
            eng_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef GD_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        eng_x_q     <= req_x[gnt_idx*Q_W +: Q_W];
                        rsp_id_q    <= gnt_idx;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_RUN;
`ifdef GD_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // A done level already present on entry counts too.
                    if (eng_done) begin
                        rsp_x_q     <= eng_x_at_min;
                        rsp_y_q     <= eng_y_min;
                        eng_start_q <= 1'b0;
                        state_q     <= ST_DRAIN;
`ifdef GD_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_x_q     <= '0;
                        rsp_y_q     <= '0;
                        err_q       <= 1'b1;
                        eng_start_q <= 1'b0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    // Wait for the engine to drop done so the next job's
                    // start is not mistaken for an instant completion.
                    if (!eng_done) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        last_grant_q <= rsp_id_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign eng_start    = eng_start_q;
    assign eng_x_in     = eng_x_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_x_at_min = rsp_x_q;
    assign rsp_y_min    = rsp_y_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

`ifdef GD_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/gd_engine_scheduler.md
GD_ENGINE_SCHEDULER -- requirements
Module: gd_engine_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one gradient-descent engine; legal range is 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the engine watchdog limit in clock cycles; it is used only when GD_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  per-requester job request.
REQ-006 Port req_x  input  32*NUM_REQ  per-requester initial x, Q24.8 signed; slice i = bits [32i+31:32i].
REQ-007 Port req_ready  output  NUM_REQ  one-hot acceptance pulse.
REQ-008 Port rsp_valid  output  1  result available.
REQ-009 Port rsp_ready  input  1  result consumer ready.
REQ-010 Port rsp_id  output  clog2(NUM_REQ)  index of the requester owning the result.
REQ-011 Port rsp_x_at_min  output  32  Q24.8 x at minimum.
REQ-012 Port rsp_y_min  output  32  Q24.8 minimum value.
REQ-013 Port rsp_err  output  1  job aborted by the watchdog.
REQ-014 Port eng_start  output  1  level start to the engine.
REQ-015 Port eng_x_in  output  32  initial x to the engine.
REQ-016 Port eng_done  input  1  engine completion level.
REQ-017 Port eng_x_at_min, eng_y_min  input  32 each  engine results.
REQ-018 Port busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and RESP.
REQ-020 In IDLE with any req_valid set, the block SHALL grant one requester round-robin, starting the search at last_grant+1 modulo NUM_REQ.
REQ-021 On the grant cycle, the block SHALL assert req_ready for the granted index only, latch its req_x and index, and move to RUN.
REQ-022 req_ready SHALL be high only in IDLE on a grant and SHALL be high for exactly one cycle per job.
REQ-023 In RUN, eng_start SHALL be 1 and eng_x_in SHALL hold the latched x; eng_start first rises the cycle after the grant.
REQ-024 In RUN with eng_done=1, the block SHALL latch eng_x_at_min and eng_y_min, set the result error flag to 0, and move to DRAIN.
REQ-025 In DRAIN, eng_start SHALL be 0, and the block SHALL move to RESP only on a cycle where eng_done=0.
REQ-026 In RESP, rsp_valid SHALL be 1 and rsp_id/rsp_x_at_min/rsp_y_min/rsp_err SHALL stay stable until rsp_valid&&rsp_ready.
REQ-027 On rsp_valid&&rsp_ready, the block SHALL update last_grant to rsp_id and return to IDLE.
REQ-028 No new grant SHALL occur before the return to IDLE, so the minimum job-to-job spacing is one IDLE cycle.
REQ-029 req_valid deasserting after a grant SHALL NOT affect the running job.
REQ-030 If eng_done is already 1 on RUN entry, the block SHALL treat it as completion.

Reset
REQ-031 While rst=1, the block SHALL enter IDLE and drive req_ready=0, rsp_valid=0, rsp_err=0, eng_start=0, busy=0, rsp_id=0, rsp_x_at_min=0, rsp_y_min=0 and eng_x_in=0.
REQ-032 While rst=1, the block SHALL set last_grant to NUM_REQ-1 so that requester 0 wins first.
REQ-033 A reset asserted in any state SHALL abort the job without issuing a response, and the values of REQ-031 SHALL be visible the cycle after the reset edge.

Configuration
REQ-034 With macro GD_TIMEOUT_EN defined, a cycle counter SHALL clear on RUN entry and increment each cycle in RUN.
REQ-035 With GD_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYCLES-1 without eng_done, the block SHALL latch results as 0, set rsp_err=1, and go to DRAIN.
REQ-036 Without GD_TIMEOUT_EN, the counter SHALL be absent, RUN SHALL wait indefinitely, and rsp_err SHALL be constant 0.

Structure
REQ-037 Shared package gd_pkg SHALL hold the Q24.8 word width (32), the fraction bits (8), the Q24.8 typedef, and the scheduler state encoding.
REQ-038 Round-robin selection SHALL be one sub-module, gd_rr_arbiter, which is purely combinational over the request vector and the last_grant pointer.

Verification
REQ-039 After reset, req_valid=4'b0100 and req_x[2]=0x00000A00 SHALL give req_ready=4'b0100 for one cycle, then eng_x_in=0x00000A00 with eng_start=1, then rsp_id=2 with the engine results and rsp_err=0.
REQ-040 With req_valid=4'b1111 held after reset, grants SHALL occur in order 0,1,2,3.
REQ-041 With last_grant=3 and req_valid=4'b1010, grants SHALL occur in order 1 then 3.
REQ-042 With rsp_ready=0 for 10 cycles in RESP, rsp_valid and the data SHALL stay stable, with eng_start=0 and req_ready=0 throughout.
REQ-043 With eng_done held 1 for 3 cycles after eng_start drops, the block SHALL stay in DRAIN 3 cycles and then enter RESP.
REQ-044 A reset pulse in RUN SHALL give eng_start=0, busy=0 and rsp_valid=0 next cycle; with GD_TIMEOUT_EN and eng_done stuck 0, the block SHALL return rsp_err=1 and rsp_x_at_min=0 after 64 RUN cycles.
